pdp8_mri_exec: RTL and testbench

PDP8_MRI_EXEC -- requirements
Module: pdp8_mri_exec

---
 rtl/pdp8_mri_exec.sv | 130 +++++++++++++
 tb/tb_pdp8_mri_exec.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pdp8_mri_exec.sv
// pdp8_mri_exec: executes PDP-8 memory-reference instructions (AND/TAD/ISZ/DCA/JMS/JMP)
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

module pdp8_mri_exec (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   mri_valid,
   input  logic [`ADDR_WIDTH+5:0] mri_op,
   input  logic [`ADDR_WIDTH-1:0] mri_pc,
   output logic                   mri_ready,
   output logic                   mem_req,
   output logic                   mem_we,
   output logic [`ADDR_WIDTH-1:0] mem_addr,
   output logic [`DATA_WIDTH-1:0] mem_wdata,
   input  logic                   mem_ack,
   input  logic [`DATA_WIDTH-1:0] mem_rdata,
   output logic [`DATA_WIDTH-1:0] ac_out,
   output logic                   link_out,
   output logic                   pc_load,
   output logic [`ADDR_WIDTH-1:0] pc_next
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;
   // Ordering matters: kinds up to ISZ read memory, DCA/JMS write it, the rest go straight to DONE.
   localparam logic [2:0] K_AND = 3'd0;
   localparam logic [2:0] K_TAD = 3'd1;
   localparam logic [2:0] K_ISZ = 3'd2;
   localparam logic [2:0] K_DCA = 3'd3;
   localparam logic [2:0] K_JMS = 3'd4;
   localparam logic [2:0] K_JMP = 3'd5;
   localparam logic [2:0] K_NOP = 3'd6;

   logic [1:0]              state_q, state_d;
   logic [2:0]              kind_q, kind_d, dec_kind;
   logic [`ADDR_WIDTH-1:0]  addr_q, addr_d, pc_q, pc_d, pcn_q, pcn_d, pc_calc;
   logic [`DATA_WIDTH-1:0]  ac_q, ac_d, m_q, m_d;
   logic                    link_q, link_d;
   logic [`DATA_WIDTH:0]    sum;

   // Priority decode of the one-hot flags (AND highest); nothing set means no-op.
   always_comb begin
      dec_kind = mri_op[`ADDR_WIDTH+5] ? K_AND :
                 mri_op[`ADDR_WIDTH+4] ? K_TAD :
                 mri_op[`ADDR_WIDTH+3] ? K_ISZ :
                 mri_op[`ADDR_WIDTH+2] ? K_DCA :
                 mri_op[`ADDR_WIDTH+1] ? K_JMS :
                 mri_op[`ADDR_WIDTH]   ? K_JMP : K_NOP;
      sum      = {1'b0, ac_q} + {1'b0, mem_rdata};
      pc_calc  = (kind_q == K_JMP) ? addr_q :
                 (kind_q == K_JMS) ? addr_q + 12'd1 :
                 (kind_q == K_ISZ && m_q == '0) ? pc_q + 12'd2 : pc_q + 12'd1;
   end

   // Next-state and datapath updates; memory results only take effect on ack.
   always_comb begin
      state_d = state_q;
      kind_d  = kind_q;
      addr_d  = addr_q;
      pc_d    = pc_q;
      pcn_d   = pcn_q;
      ac_d    = ac_q;
      m_d     = m_q;
      link_d  = link_q;
      case (state_q)
         S_IDLE: if (mri_valid) begin
            kind_d  = dec_kind;
            addr_d  = mri_op[`ADDR_WIDTH-1:0];
            pc_d    = mri_pc;
            state_d = (dec_kind <= K_ISZ) ? S_READ : (dec_kind <= K_JMS) ? S_WRITE : S_DONE;
         end
         S_READ: if (mem_ack) begin
            ac_d    = (kind_q == K_AND) ? (ac_q & mem_rdata) : (kind_q == K_TAD) ? sum[`DATA_WIDTH-1:0] : ac_q;
            link_d  = link_q ^ ((kind_q == K_TAD) & sum[`DATA_WIDTH]);
            m_d     = mem_rdata + 12'd1;
            state_d = (kind_q == K_ISZ) ? S_WRITE : S_DONE;
         end
         S_WRITE: if (mem_ack) begin
            ac_d    = (kind_q == K_DCA) ? '0 : ac_q;
            state_d = S_DONE;
         end
         default: begin
            pcn_d   = pc_calc;
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers; async reset aborts any access in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         kind_q  <= K_NOP;
         addr_q  <= '0;
         pc_q    <= '0;
         pcn_q   <= '0;
         ac_q    <= '0;
         m_q     <= '0;
         link_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         kind_q  <= kind_d;
         addr_q  <= addr_d;
         pc_q    <= pc_d;
         pcn_q   <= pcn_d;
         ac_q    <= ac_d;
         m_q     <= m_d;
         link_q  <= link_d;
      end
   end

   // Request fields derive from registered state only, so they stay stable until ack.
   always_comb begin
      mri_ready = (state_q == S_IDLE);
      mem_req   = (state_q == S_READ) | (state_q == S_WRITE);
      mem_we    = (state_q == S_WRITE);
      mem_addr  = mem_req ? addr_q : '0;
      mem_wdata = !mem_we ? '0 : (kind_q == K_DCA) ? ac_q : (kind_q == K_JMS) ? pc_q + 12'd1 : m_q;
      pc_load   = (state_q == S_DONE);
      pc_next   = pc_load ? pc_calc : pcn_q;
      ac_out    = ac_q;
      link_out  = link_q;
   end
endmodule

// File: tb/tb_pdp8_mri_exec.sv
// tb_pdp8_mri_exec: directed checks of the PDP-8 memory-reference executor
module tb_pdp8_mri_exec;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        mri_valid = 1'b0;
   logic [17:0] mri_op = '0;
   logic [11:0] mri_pc = '0;
   logic        mri_ready, mem_req, mem_we, mem_ack = 1'b0;
   logic [11:0] mem_addr, mem_wdata, mem_rdata = '0, ac_out, pc_next;
   logic        link_out, pc_load;

   int          n_cmp = 0, n_err = 0;
   int          lat, reads, writes, req_cycles;
   logic [11:0] wr_addr, wr_data, pcn;
   bit          unstable, seen_load;

   localparam logic [5:0] F_AND = 6'b100000;
   localparam logic [5:0] F_TAD = 6'b010000;
   localparam logic [5:0] F_ISZ = 6'b001000;
   localparam logic [5:0] F_DCA = 6'b000100;
   localparam logic [5:0] F_JMS = 6'b000010;
   localparam logic [5:0] F_JMP = 6'b000001;

   pdp8_mri_exec dut (
      .clk(clk), .reset_n(reset_n), .mri_valid(mri_valid), .mri_op(mri_op), .mri_pc(mri_pc),
      .mri_ready(mri_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ac_out(ac_out),
      .link_out(link_out), .pc_load(pc_load), .pc_next(pc_next)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0o expected %0o", tag, got, exp);
      end
   endtask

   // Issue one instruction and act as memory with wt wait cycles per access.
   task automatic exec(input logic [5:0] f, input logic [11:0] a, input logic [11:0] pc,
                       input logic [11:0] m, input int wt, input bit hold);
      logic [24:0] held = '0;
      bit          pend = 0, done = 0, ack;
      int          stall = 0, c = 0;
      lat = 0; reads = 0; writes = 0; req_cycles = 0; unstable = 0;
      wr_addr = '0; wr_data = '0; pcn = '0;
      mri_valid = 1'b1; mri_op = {f, a}; mri_pc = pc; mem_rdata = m;
      @(posedge clk); #1;
      if (!hold) mri_valid = 1'b0;
      while (!done && c < 20) begin
         c++;
         if (mem_req) begin
            if (pend && {mem_we, mem_addr, mem_wdata} !== held) unstable = 1;
            held = {mem_we, mem_addr, mem_wdata};
            req_cycles++;
            ack = (stall == wt);
            mem_ack = ack;
            if (ack && mem_we) begin writes++; wr_addr = mem_addr; wr_data = mem_wdata; end
            if (ack && !mem_we) reads++;
            stall = ack ? 0 : stall + 1;
            pend = !ack;
         end else begin
            if (pend) unstable = 1;
            pend = 0;
         end
         if (pc_load) begin lat = c; pcn = pc_next; done = 1; end
         @(posedge clk); #1;
         mem_ack = 1'b0;
      end
      mri_valid = 1'b0;
   endtask

   initial begin
      #3;
      check("rst_ac", ac_out, 0);
      check("rst_link", link_out, 0);
      check("rst_pcnext", pc_next, 0);
      check("rst_req", {mem_req, mem_we, mem_addr, mem_wdata, pc_load}, 0);
      check("rst_ready", mri_ready, 1);
      #9 reset_n = 1'b1;
      @(posedge clk); #1;

      exec(F_TAD, 12'o0050, 12'o0100, 12'o7777, 0, 0);
      check("tad1_ac", ac_out, 12'o7777);
      check("tad1_link", link_out, 0);
      check("tad1_pc", pcn, 12'o0101);

      exec(F_TAD, 12'o0051, 12'o0200, 12'o0001, 0, 0);
      check("tad2_ac", ac_out, 12'o0000);
      check("tad2_link", link_out, 1);
      check("tad2_pc", pcn, 12'o0201);
      check("tad2_lat", lat, 2);
      check("tad2_reads", reads, 1);

      exec(F_ISZ, 12'o0060, 12'o7777, 12'o7777, 0, 0);
      check("isz_wrap_rw", {reads[3:0], writes[3:0]}, 8'h11);
      check("isz_wrap_wd", wr_data, 12'o0000);
      check("isz_wrap_wa", wr_addr, 12'o0060);
      check("isz_wrap_pc", pcn, 12'o0001);
      check("isz_wrap_lat", lat, 3);

      exec(F_ISZ, 12'o0061, 12'o0010, 12'o0005, 0, 0);
      check("isz_wd", wr_data, 12'o0006);
      check("isz_pc", pcn, 12'o0011);

      exec(F_JMS, 12'o0300, 12'o0205, 12'o0000, 0, 0);
      check("jms_wa", wr_addr, 12'o0300);
      check("jms_wd", wr_data, 12'o0206);
      check("jms_pc", pcn, 12'o0301);
      check("jms_lat", lat, 2);
      check("jms_reads", reads, 0);

      exec(F_TAD, 12'o0052, 12'o0210, 12'o1234, 0, 0);
      check("tad3_ac", ac_out, 12'o1234);
      check("tad3_link", link_out, 1);

      exec(F_DCA, 12'o0400, 12'o0211, 12'o0000, 3, 0);
      check("dca_reqcyc", req_cycles, 4);
      check("dca_stable", unstable, 0);
      check("dca_wd", wr_data, 12'o1234);
      check("dca_wa", wr_addr, 12'o0400);
      check("dca_ac", ac_out, 12'o0000);
      check("dca_lat", lat, 5);
      check("dca_pc", pcn, 12'o0212);

      exec(F_TAD, 12'o0053, 12'o0212, 12'o7070, 0, 0);
      exec(F_AND, 12'o0054, 12'o0213, 12'o1717, 1, 0);
      check("and_ac", ac_out, 12'o1010);
      check("and_lat", lat, 3);
      check("and_stable", unstable, 0);

      exec(F_TAD, 12'o0055, 12'o0214, 12'o7000, 0, 0);
      check("tad4_ac", ac_out, 12'o0010);
      check("tad4_link", link_out, 0);

      exec(F_JMP, 12'o0400, 12'o0215, 12'o0000, 0, 1);
      check("jmp_noreq", req_cycles, 0);
      check("jmp_pc", pcn, 12'o0400);
      check("jmp_lat", lat, 1);
      check("jmp_no2nd", {pc_load, mem_req, mri_ready}, 3'b001);
      check("jmp_hold", pc_next, 12'o0400);

      exec(6'b000000, 12'o0123, 12'o0777, 12'o0000, 0, 0);
      check("nop_pc", pcn, 12'o1000);
      check("nop_lat", lat, 1);
      check("nop_noreq", req_cycles, 0);

      exec(F_TAD | F_DCA, 12'o0056, 12'o0300, 12'o0001, 0, 0);
      check("prio_rw", {reads[3:0], writes[3:0]}, 8'h10);
      check("prio_ac", ac_out, 12'o0011);

      exec(F_JMS, 12'o7777, 12'o7777, 12'o0000, 0, 0);
      check("jms_wrap_wd", wr_data, 12'o0000);
      check("jms_wrap_pc", pcn, 12'o0000);

      mem_ack = 1'b1; mem_rdata = 12'o7777;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      check("idle_ack", {mem_req, pc_load, mri_ready}, 3'b001);
      check("idle_ack_ac", ac_out, 12'o0011);

      mri_valid = 1'b1; mri_op = {F_TAD, 12'o0070}; mri_pc = 12'o0500; mem_ack = 1'b0;
      @(posedge clk); #1;
      mri_valid = 1'b0;
      check("rst_mid_req", mem_req, 1);
      @(posedge clk); #2;
      reset_n = 1'b0; #1;
      check("rst_mid_drop", {mem_req, pc_load}, 2'b00);
      check("rst_mid_ac", ac_out, 0);
      #4 reset_n = 1'b1;
      seen_load = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         seen_load |= pc_load;
      end
      check("rst_mid_noload", seen_load, 0);
      check("rst_mid_ready", mri_ready, 1);
      check("rst_mid_ac2", ac_out, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
